instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, drives instruction memory and loads the IF/ID register.
// A two-state RUN/HALT machine stops fetching at the end of memory or on a zero word.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 64,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] target_f;
  logic        halt_cond;
  logic        go_halt;
  logic        load;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;
  assign target_f   = branch_target & 32'hFFFF_FFFC;
  assign halt_cond  = (pc_f >= PC_LIMIT) || (HALT_ON_ZERO && (imem_rd == 32'h0));

  // A redirect overrides the halt condition, so the current word is still issued.
  assign go_halt = (state == RUN) && !pc_src && !stall && halt_cond;
  assign load    = (state == RUN) && !stall && (pc_src || !halt_cond);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc_f        <= RESET_PC;
      instr_d     <= 32'h0;
      pc_d        <= 32'h0;
      pc_plus4_d  <= 32'h0;
      valid_d     <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      if (state == RUN) begin
        if (pc_src) begin
          pc_f <= target_f;
        end else if (!stall) begin
          if (halt_cond) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc_f <= pc_plus4_f;
          end
        end
      end else if (pc_src) begin
        pc_f   <= target_f;
        state  <= RUN;
        halted <= 1'b0;
      end

      if (flush) begin
        instr_d    <= 32'h0;
        pc_d       <= 32'h0;
        pc_plus4_d <= 32'h0;
        valid_d    <= 1'b0;
      end else if (load) begin
        instr_d     <= imem_rd;
        pc_d        <= pc_f;
        pc_plus4_d  <= pc_plus4_f;
        valid_d     <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else if (go_halt || (state == HALT)) begin
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 64-word instruction memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr[31:8] == 24'h0) ? mem[imem_addr[7:2]] : 32'hFFFF_FFFF;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .branch_target(branch_target),
    .stall(stall), .flush(flush), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'hE3A0_A00A;
    reset = 1'b1; pc_src = 1'b0; branch_target = 32'h0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, valid_d}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_instr", instr_d, 32'h0);

    // first fetch
    reset = 1'b0;
    tick();
    chk("f0_instr", instr_d, 32'hE3A0_A00A);
    chk("f0_pc", pc_d, 32'h0);
    chk("f0_pc4", pc_plus4_d, 32'h4);
    chk("f0_valid", {31'h0, valid_d}, 32'h1);
    chk("f0_addr", imem_addr, 32'h4);
    chk("f0_count", fetch_count, 32'h1);

    // stall at pc 8
    tick();
    chk("f1_addr", imem_addr, 32'h8);
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", pc_d, 32'h4);
    chk("stall_instr", instr_d, 32'hA000_0001);
    chk("stall_count", fetch_count, 32'h2);
    stall = 1'b0;
    tick();
    chk("unstall_addr", imem_addr, 32'hC);
    chk("unstall_pc", pc_d, 32'h8);
    chk("unstall_count", fetch_count, 32'h3);

    // redirect with flush at pc 0x10
    tick();
    chk("pre_br_addr", imem_addr, 32'h10);
    pc_src = 1'b1; branch_target = 32'h16; flush = 1'b1;
    tick();
    chk("br_addr", imem_addr, 32'h14);
    chk("br_valid", {31'h0, valid_d}, 32'h0);
    chk("br_instr", instr_d, 32'h0);
    chk("br_count", fetch_count, 32'h4);
    pc_src = 1'b0; flush = 1'b0;
    tick();
    chk("tgt_instr", instr_d, 32'hA000_0005);
    chk("tgt_pc", pc_d, 32'h14);
    chk("tgt_valid", {31'h0, valid_d}, 32'h1);
    chk("tgt_count", fetch_count, 32'h5);

    // zero word at 0x28 halts
    mem[10] = 32'h0;
    repeat (4) tick();
    chk("z_pre_addr", imem_addr, 32'h28);
    chk("z_pre_count", fetch_count, 32'h9);
    tick();
    chk("z_halted", {31'h0, halted}, 32'h1);
    chk("z_valid", {31'h0, valid_d}, 32'h0);
    chk("z_addr", imem_addr, 32'h28);
    chk("z_count", fetch_count, 32'h9);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("z_hold_halted", {31'h0, halted}, 32'h1);
    chk("z_hold_addr", imem_addr, 32'h28);

    // async reset while halted
    #2;
    reset = 1'b1;
    #1;
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_halted", {31'h0, halted}, 32'h0);
    chk("ar_valid", {31'h0, valid_d}, 32'h0);
    chk("ar_count", fetch_count, 32'h0);
    chk("ar_instr", instr_d, 32'h0);
    chk("ar_pc", pc_d, 32'h0);
    chk("ar_pc4", pc_plus4_d, 32'h0);
    tick();
    reset = 1'b0;

    // zero word again, redirect in the same cycle wins
    repeat (10) tick();
    chk("zr_pre_addr", imem_addr, 32'h28);
    chk("zr_pre_count", fetch_count, 32'hA);
    pc_src = 1'b1; branch_target = 32'h40;
    tick();
    pc_src = 1'b0;
    chk("zr_halted", {31'h0, halted}, 32'h0);
    chk("zr_valid", {31'h0, valid_d}, 32'h1);
    chk("zr_instr", instr_d, 32'h0);
    chk("zr_pc", pc_d, 32'h28);
    chk("zr_addr", imem_addr, 32'h40);
    chk("zr_count", fetch_count, 32'hB);

    // run off the end of memory
    mem[10] = 32'hA000_000A;
    repeat (48) tick();
    chk("end_addr", imem_addr, 32'h100);
    chk("end_pc", pc_d, 32'hFC);
    chk("end_pc4", pc_plus4_d, 32'h100);
    chk("end_count", fetch_count, 32'd59);
    tick();
    chk("oor_halted", {31'h0, halted}, 32'h1);
    chk("oor_valid", {31'h0, valid_d}, 32'h0);
    chk("oor_addr", imem_addr, 32'h100);
    chk("oor_count", fetch_count, 32'd59);
    tick();
    chk("oor_hold_addr", imem_addr, 32'h100);
    pc_src = 1'b1; branch_target = 32'h0;
    tick();
    pc_src = 1'b0;
    chk("wake_halted", {31'h0, halted}, 32'h0);
    chk("wake_addr", imem_addr, 32'h0);
    chk("wake_valid", {31'h0, valid_d}, 32'h0);
    chk("wake_count", fetch_count, 32'd59);
    tick();
    chk("wake_instr", instr_d, 32'hE3A0_A00A);
    chk("wake_valid2", {31'h0, valid_d}, 32'h1);
    chk("wake_count2", fetch_count, 32'd60);

    // redirect during stall, then flush during stall
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'h23;
    tick();
    pc_src = 1'b0;
    chk("sbr_addr", imem_addr, 32'h20);
    chk("sbr_pc", pc_d, 32'h0);
    chk("sbr_valid", {31'h0, valid_d}, 32'h1);
    chk("sbr_count", fetch_count, 32'd60);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("sfl_valid", {31'h0, valid_d}, 32'h0);
    chk("sfl_instr", instr_d, 32'h0);
    chk("sfl_addr", imem_addr, 32'h20);
    chk("sfl_count", fetch_count, 32'd60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
